// File: rtl/vxe_regio_ctrl.sv
// vxe_regio_ctrl: request/response front end for a bank of vxe_reg_rst registers.
//   Accepts one read/write request at a time (valid/ready), pulses the addressed
//   register's write enable for one cycle, and returns a completion (read data or
//   zero for writes) over a valid/ready response channel. Three-state FSM:
//   IDLE -> EXEC -> RESP -> IDLE, so a request takes 3 cycles without back-pressure.
// Ports:
//   clk, nrst                  clock (rising edge), synchronous active-low reset
//   i_req_vld/o_req_rdy        request handshake; i_req_wr/addr/data request fields
//   o_rsp_vld/i_rsp_rdy        response handshake; o_rsp_data/o_rsp_err response fields
//   o_reg_wr_en, o_reg_data    one-hot write enable and write data to the register bank
//   i_reg_data                 register bank outputs, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
// Configuration:
//   VXE_REGIO_ADDR_ERR_EN      when defined, out-of-range requests complete with
//                              o_rsp_err=1; otherwise o_rsp_err is always 0.
module vxe_regio_ctrl #(
  parameter int NREGS      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        i_req_vld,
  output logic                        o_req_rdy,
  input  logic                        i_req_wr,
  input  logic [ADDR_WIDTH-1:0]       i_req_addr,
  input  logic [DATA_WIDTH-1:0]       i_req_data,
  output logic                        o_rsp_vld,
  input  logic                        i_rsp_rdy,
  output logic [DATA_WIDTH-1:0]       o_rsp_data,
  output logic                        o_rsp_err,
  output logic [NREGS-1:0]            o_reg_wr_en,
  output logic [DATA_WIDTH-1:0]       o_reg_data,
  input  logic [NREGS*DATA_WIDTH-1:0] i_reg_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  state_t                  state_q,     state_d;
  logic                    req_rdy_q,   req_rdy_d;
  logic                    wr_q,        wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic                    rsp_vld_q,   rsp_vld_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic [NREGS-1:0]        reg_wr_en_q, reg_wr_en_d;
  logic [DATA_WIDTH-1:0]   reg_data_q,  reg_data_d;

  logic                    accept;
  logic                    rsp_done;
  logic                    addr_hit;
  logic [DATA_WIDTH-1:0]   rd_sel;

  // req_rdy_q already implies IDLE, so it alone qualifies the accept.
  assign accept   = i_req_vld & req_rdy_q;
  assign rsp_done = rsp_vld_q & i_rsp_rdy;

  // Read mux over the captured address; addr_hit is low for out-of-range indices.
  always_comb begin
    addr_hit = 1'b0;
    rd_sel   = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (addr_q == ADDR_WIDTH'(k)) begin
        addr_hit = 1'b1;
        rd_sel   = i_reg_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      req_rdy_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      reg_wr_en_q <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_rdy_q   <= req_rdy_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_data_q  <= reg_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)   state_d = ST_EXEC;
      ST_EXEC:               state_d = ST_RESP;
      ST_RESP: if (rsp_done) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_rdy_d   = (state_d == ST_IDLE);
    wr_d        = wr_q;
    addr_d      = addr_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    reg_wr_en_d = '0;
    reg_data_d  = reg_data_q;

    // Write enable is decoded at accept so it is registered and live for the EXEC cycle.
    if (state_q == ST_IDLE && accept) begin
      wr_d   = i_req_wr;
      addr_d = i_req_addr;
      if (i_req_wr) begin
        for (int unsigned k = 0; k < NREGS; k++) begin
          if (i_req_addr == ADDR_WIDTH'(k)) begin
            reg_wr_en_d[k] = 1'b1;
            reg_data_d     = i_req_data;
          end
        end
      end
    end

    if (state_q == ST_EXEC) begin
      rsp_vld_d  = 1'b1;
      rsp_data_d = (!wr_q && addr_hit) ? rd_sel : '0;
`ifdef VXE_REGIO_ADDR_ERR_EN
      rsp_err_d  = !addr_hit;
`else
      rsp_err_d  = 1'b0;
`endif
    end

    if (state_q == ST_RESP && rsp_done) begin
      rsp_vld_d  = 1'b0;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
    end
  end

  assign o_req_rdy   = req_rdy_q;
  assign o_rsp_vld   = rsp_vld_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_reg_wr_en = reg_wr_en_q;
  assign o_reg_data  = reg_data_q;

endmodule
